// File: rtl/instr_byte_serializer_if.sv
// rtl/instr_byte_serializer_if.sv - instruction-in / serial-byte-out bus bundle for instr_byte_serializer
interface instr_byte_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] imm;
  logic        tx_ready;
  logic        data_ready;
  logic [7:0]  serial_out;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output in_valid, instr, imm, tx_ready,
    input  in_ready, data_ready, serial_out, busy, done, error
  );

  modport slave (
    input  in_valid, instr, imm, tx_ready,
    output in_ready, data_ready, serial_out, busy, done, error
  );
endinterface

// File: rtl/instr_byte_serializer.sv
// rtl/instr_byte_serializer.sv - serializes an instruction word (+ optional immediate) onto an 8-bit byte bus
// Optional trailing XOR checksum byte enabled by macro INSTR_SER_CHECKSUM_EN.
module instr_byte_serializer #(
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 4
) (
  input logic                    clk,
  input logic                    rst,
  instr_byte_serializer_if.slave bus
);

  typedef enum logic [2:0] {
    R_TYPE  = 3'd0,
    I_TYPE  = 3'd1,
    M_TYPE  = 3'd2,
    B_TYPE  = 3'd3,
    J_TYPE  = 3'd4,
    SYS_END = 3'd5
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int             GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_LOAD_I[GAP_W-1:0];

`ifdef INSTR_SER_CHECKSUM_EN
  localparam logic [2:0] LEN_SHORT = 3'd3;
  localparam logic [2:0] LEN_LONG  = 3'd5;
`else
  localparam logic [2:0] LEN_SHORT = 3'd2;
  localparam logic [2:0] LEN_LONG  = 3'd4;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_hold;
  logic [2:0]       r_count;
  logic [2:0]       r_len;
  logic [GAP_W-1:0] r_gap;
  logic             r_error;
`ifdef INSTR_SER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic [2:0] w_opcode;
  logic       w_legal;
  logic       w_is_long;
  logic       w_accept;
  logic       w_consume;
  logic       w_last;
  logic [7:0] w_byte;

  assign w_opcode = bus.instr[2:0];

  always_comb begin
    w_legal   = 1'b0;
    w_is_long = 1'b0;
    case (w_opcode)
      R_TYPE, B_TYPE, J_TYPE, SYS_END: w_legal = 1'b1;
      I_TYPE, M_TYPE: begin
        w_legal   = 1'b1;
        w_is_long = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_last = (r_count == (r_len - 3'd1));

`ifdef INSTR_SER_CHECKSUM_EN
  // The final slot of the frame carries the running XOR instead of payload.
  assign w_byte = w_last ? r_csum : r_hold[7:0];
`else
  assign w_byte = r_hold[7:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = bus.in_valid;
        if (bus.in_valid && w_legal) begin
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          w_consume = 1'b1;
          if (w_last) begin
            w_next = S_IDLE;
          end else if (GAP_CYCLES > 0) begin
            w_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_next = S_SEND;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold  <= 32'h0;
      r_count <= 3'd0;
      r_len   <= 3'd0;
      r_gap   <= '0;
      r_error <= 1'b0;
`ifdef INSTR_SER_CHECKSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      r_error <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_hold  <= {bus.imm, bus.instr};
        r_count <= 3'd0;
        r_len   <= w_is_long ? LEN_LONG : LEN_SHORT;
`ifdef INSTR_SER_CHECKSUM_EN
        r_csum  <= 8'h00;
`endif
      end else if (w_consume) begin
        r_hold  <= {8'h00, r_hold[31:8]};
        r_count <= r_count + 3'd1;
        r_gap   <= GAP_LOAD;
`ifdef INSTR_SER_CHECKSUM_EN
        r_csum  <= r_csum ^ r_hold[7:0];
`endif
      end else if (r_state == S_GAP && r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.data_ready = w_consume;
  assign bus.serial_out = w_consume ? w_byte : 8'h00;
  assign bus.done       = w_consume && w_last;
  assign bus.error      = r_error;

endmodule
